dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the processor's load/store port (address, MemRW-class control, write data in; read data out).
- Accepts one request at a time over a valid/ready handshake, runs a configurable wait-state counter, commits stores with byte lanes, and returns sign/zero-extended load data plus an error flag.
- Replaces the purely combinational data memory so the core's memory stage can tolerate multi-cycle memory.

Parameters:
- AWIDTH, 32, byte-address width.
- DWIDTH, 32, data width; fixed at 32 (RV32 lanes).
- DEPTH, 1024, memory size in 32-bit words; power of two.
- WAIT_CYCLES, 2, wait states between accept and response; range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  AWIDTH  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- req_wdata  in  DWIDTH  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  DWIDTH  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE.
  - req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Wait counter = 0; latched request fields = 0.
  - Memory array is not cleared.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch addr/we/funct3/wdata. Go to WAIT with counter = WAIT_CYCLES−1, or directly to RESP if WAIT_CYCLES = 0.
  - WAIT: req_ready = 0. Decrement counter each cycle; at counter = 0, go to RESP.
  - RESP: rsp_valid = 1, held with stable rsp_rdata/rsp_err until rsp_valid & rsp_ready. Then go to IDLE; req_ready rises the following cycle (no back-to-back accept in the RESP exit cycle).
- Latency: accept edge to first rsp_valid cycle = WAIT_CYCLES + 1 clocks.
- Execution point: the array access (read, or byte-lane write) and error check happen on the edge that enters RESP. rsp_* are registered on that same edge.
- Word index = addr[log2(DEPTH)+1 : 2]. Byte offset = addr[1:0].
- Error conditions (rsp_err = 1, rsp_rdata = 0, no write):
  - Any address bit above the index range is nonzero.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - funct3 ∈ {3, 6, 7} for loads, or funct3 ∉ {0, 1, 2} for stores.
- Stores:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1], 0} and {addr[1], 1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged; rsp_rdata = 0.
- Loads:
  - Extract the selected byte/half from the word.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word through.
- Inputs in WAIT/RESP are ignored; only latched fields are used.
- rsp_ready asserted while not in RESP has no effect.
- Reset mid-operation (WAIT or RESP):
  - Abort; a pending store is not committed if reset precedes the RESP entry edge.
  - A store already committed stays in memory.

Decomposition:
- Shared package dmem_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding IDLE/WAIT/RESP.
  - Lane-select helper function.
- One natural sub-module: dmem_lane_align. It is combinational, and does store byte-enable/data replication plus load extract/extend. It is unit-testable on its own.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_err = 0, rsp_rdata = 0xDEADBEEF; each rsp_valid rises exactly 3 clocks after accept (WAIT_CYCLES = 2).
- After the above: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF. SH 0x12 data 0x1234, then LW → 0x123455EF.
- LW 0x11 → rsp_err = 1, rdata = 0. SH 0x15 → err, word 0x14 unchanged. LW 0x1000 (DEPTH = 1024) → err. Load funct3 = 3 → err.
- Backpressure: hold rsp_ready = 0 for 5 cycles → rsp_valid/rdata stable, req_ready = 0 throughout; release → req_ready = 1 one cycle after the handshake.
- Drive rst low during WAIT of SW 0x20 data 0xA5A5A5A5 → outputs at reset values immediately. After release, LW 0x20 returns its pre-store value. Repeat the directed tests with WAIT_CYCLES = 0 → latency 1 clock.

Source files
------------

// File: rtl/dmem_pkg.sv
// ------------------------------------------------------------------
// dmem_pkg: shared funct3 codes, FSM states and lane helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given width at the given offset.
  function automatic logic [3:0] lane_sel(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << offset;
      F3_H, F3_HU: m = 4'b0011 << {offset[1], 1'b0};
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ------------------------------------------------------------------
// dmem_lane_align: store lane enables/replication, load extract/extend
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic        misalign_w;
  logic        illegal_w;

  always_comb begin
    byte_w = rword_i[{offset_i, 3'b000} +: 8];
    half_w = rword_i[{offset_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3_H, F3_HU: misalign_w = offset_i[0];
      F3_W:        misalign_w = |offset_i;
      default:     misalign_w = 1'b0;
    endcase

    if (we_i) illegal_w = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
    else      illegal_w = (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7);

    err_o = misalign_w | illegal_w;
    be_o  = (we_i && !err_o) ? lane_sel(funct3_i, offset_i) : 4'b0000;

    case (funct3_i)
      F3_B:    wdata_o = {4{wdata_i[7:0]}};
      F3_H:    wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase

    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_w[7]}}, byte_w};
      F3_BU:   rdata_o = {24'd0, byte_w};
      F3_H:    rdata_o = {{16{half_w[15]}}, half_w};
      F3_HU:   rdata_o = {16'd0, half_w};
      F3_W:    rdata_o = rword_i;
      default: rdata_o = 32'd0;
    endcase
    if (we_i || err_o) rdata_o = 32'd0;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ------------------------------------------------------------------
// dmem_responder: handshaked data-memory target with wait states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int         IW       = $clog2(DEPTH);
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [AWIDTH-1:0]   addr_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DWIDTH-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [DWIDTH-1:0]   mem_q [DEPTH];

  logic                accept_w;
  logic                in_idle_w;
  logic                enter_resp_w;
  logic                commit_w;
  logic [AWIDTH-1:0]   acc_addr_w;
  logic                acc_we_w;
  logic [2:0]          acc_funct3_w;
  logic [DWIDTH-1:0]   acc_wdata_w;
  logic [IW-1:0]       idx_w;
  logic                oor_w;
  logic                align_err_w;
  logic                acc_err_w;
  logic [3:0]          be_w;
  logic [31:0]         st_data_w;
  logic [31:0]         ld_data_w;
  logic [DWIDTH-1:0]   rsp_data_w;

  // With no wait states the access happens on the accept edge, so it
  // must see the live request rather than the (not yet) latched copy.
  assign in_idle_w    = (state_q == ST_IDLE);
  assign accept_w     = req_valid_i & req_ready_q;
  assign acc_addr_w   = in_idle_w ? req_addr_i   : addr_q;
  assign acc_we_w     = in_idle_w ? req_we_i     : we_q;
  assign acc_funct3_w = in_idle_w ? req_funct3_i : funct3_q;
  assign acc_wdata_w  = in_idle_w ? req_wdata_i  : wdata_q;

  assign enter_resp_w = (in_idle_w && accept_w && NO_WAIT) ||
                        (state_q == ST_WAIT && cnt_q == 4'd0);

  assign idx_w      = acc_addr_w[IW+1:2];
  assign oor_w      = |acc_addr_w[AWIDTH-1:IW+2];
  assign acc_err_w  = oor_w | align_err_w;
  assign commit_w   = enter_resp_w & acc_we_w & ~acc_err_w & rst_ni;
  assign rsp_data_w = acc_err_w ? '0 : ld_data_w;

  dmem_lane_align u_align (
    .we_i     (acc_we_w),
    .funct3_i (acc_funct3_w),
    .offset_i (acc_addr_w[1:0]),
    .wdata_i  (acc_wdata_w),
    .rword_i  (mem_q[idx_w]),
    .be_o     (be_w),
    .wdata_o  (st_data_w),
    .rdata_o  (ld_data_w),
    .err_o    (align_err_w)
  );

  always_ff @(posedge clk_i) begin
    if (commit_w) begin
      for (int i = 0; i < 4; i++) begin
        if (be_w[i]) mem_q[idx_w][8*i +: 8] <= st_data_w[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            addr_q      <= req_addr_i;
            we_q        <= req_we_i;
            funct3_q    <= req_funct3_i;
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_INIT;
            state_q     <= NO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (enter_resp_w) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_data_w;
        rsp_err_q   <= acc_err_w;
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ------------------------------------------------------------------
// tb_dmem_responder: two responders (2 and 0 wait states) vs byte model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  logic [7:0]  bm [2][4*DEPTH];
  int          n_checks = 0;
  int          n_pass   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 2 : 0)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n[g]),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_addr_i   (req_addr[g]),
      .req_we_i     (req_we[g]),
      .req_funct3_i (req_funct3[g]),
      .req_wdata_i  (req_wdata[g]),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_ready_i  (rsp_ready[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .rsp_err_o    (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: byte-addressed little-endian memory, width from funct3.
  task automatic model(input int u, input logic [31:0] a, input bit we, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    int sz;
    logic [31:0] v;
    d = 0;
    e = 0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (a >= 32'(4 * DEPTH)) e = 1;
    if (sz == 0) e = 1;
    if (we && f3 > 3'd2) e = 1;
    if (sz != 0 && (a % sz) != 0) e = 1;
    if (e) return;
    if (we) begin
      for (int k = 0; k < sz; k++) bm[u][a + k] = wd[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < sz; k++) v |= 32'(bm[u][a + k]) << (8 * k);
      if (f3 == 3'd0 && v[7])  v |= 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v |= 32'hFFFF_0000;
      d = v;
    end
  endtask

  task automatic txn(input int u, input logic [31:0] a, input bit we, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    model(u, a, we, f3, wd, exp_d, exp_e);
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(req_ready[u]), 32'd1);
    rsp_ready[u]  = 1'b0;
    req_valid[u]  = 1'b1;
    req_addr[u]   = a;
    req_we[u]     = we;
    req_funct3[u] = f3;
    req_wdata[u]  = wd;
    @(posedge clk); #1;
    req_valid[u]  = 1'($urandom);
    req_addr[u]   = $urandom;
    req_we[u]     = 1'($urandom);
    req_funct3[u] = 3'($urandom);
    req_wdata[u]  = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid[u] !== 1'b1) begin
        check("req_ready_busy", 32'(req_ready[u]), 32'd0);
        rsp_ready[u] = 1'($urandom);
      end
    end while (rsp_valid[u] !== 1'b1 && n < 40);
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b0;
    check("latency", 32'(n), 32'(wc(u) + 1));
    got_d = rsp_rdata[u];
    got_e = rsp_err[u];
    check("rdata", got_d, exp_d);
    check("err", 32'(got_e), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[u]), 32'd1);
      check("hold_rdata", rsp_rdata[u], got_d);
      check("hold_ready", 32'(req_ready[u]), 32'd0);
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid[u]), 32'd0);
    check("post_ready", 32'(req_ready[u]), 32'd1);
  endtask

  task automatic reset_mid_store(input int u);
    int n;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid[u]  = 1'b1;
    req_addr[u]   = 32'h20;
    req_we[u]     = 1'b1;
    req_funct3[u] = 3'd2;
    req_wdata[u]  = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    #2;
    check("wait_ready_low", 32'(req_ready[u]), 32'd0);
    rst_n[u] = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready[u]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
    check("rst_rsp_rdata", rsp_rdata[u], 32'd0);
    check("rst_rsp_err", 32'(rsp_err[u]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n[u] = 1'b1;
  endtask

  task automatic directed(input int u);
    logic [31:0] d;
    logic        e;
    txn(u, 32'h10, 1, 3'd2, 32'hDEAD_BEEF, 0, d, e);
    txn(u, 32'h10, 0, 3'd2, 0, 0, d, e); check("lw_10", d, 32'hDEAD_BEEF);
    txn(u, 32'h13, 0, 3'd0, 0, 0, d, e); check("lb_13", d, 32'hFFFF_FFDE);
    txn(u, 32'h13, 0, 3'd4, 0, 0, d, e); check("lbu_13", d, 32'h0000_00DE);
    txn(u, 32'h12, 0, 3'd1, 0, 0, d, e); check("lh_12", d, 32'hFFFF_DEAD);
    txn(u, 32'h10, 0, 3'd5, 0, 0, d, e); check("lhu_10", d, 32'h0000_BEEF);
    txn(u, 32'h11, 1, 3'd0, 32'h55, 0, d, e);
    txn(u, 32'h10, 0, 3'd2, 0, 0, d, e); check("lw_after_sb", d, 32'hDEAD_55EF);
    txn(u, 32'h12, 1, 3'd1, 32'h1234, 0, d, e);
    txn(u, 32'h10, 0, 3'd2, 0, 0, d, e); check("lw_after_sh", d, 32'h1234_55EF);
    txn(u, 32'h11, 0, 3'd2, 0, 0, d, e); check("lw_mis_err", 32'(e), 32'd1);
    check("lw_mis_data", d, 32'd0);
    txn(u, 32'h14, 1, 3'd2, 32'hCAFE_F00D, 0, d, e);
    txn(u, 32'h15, 1, 3'd1, 32'hFFFF, 0, d, e); check("sh_mis_err", 32'(e), 32'd1);
    txn(u, 32'h14, 0, 3'd2, 0, 0, d, e); check("lw_14_kept", d, 32'hCAFE_F00D);
    txn(u, 32'h1000, 0, 3'd2, 0, 0, d, e); check("lw_oor_err", 32'(e), 32'd1);
    txn(u, 32'h10, 0, 3'd3, 0, 0, d, e); check("f3_3_err", 32'(e), 32'd1);
    txn(u, 32'h10, 0, 3'd2, 0, 5, d, e); check("bp_rdata", d, 32'h1234_55EF);
    txn(u, 32'h20, 1, 3'd2, 32'h1122_3344, 0, d, e);
    if (wc(u) > 0) reset_mid_store(u);
    txn(u, 32'h20, 0, 3'd2, 0, 0, d, e); check("lw_20_pre", d, 32'h1122_3344);
    rsp_ready[u] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_rsp_ready", 32'(rsp_valid[u]), 32'd0);
    end
    rsp_ready[u] = 1'b0;
  endtask

  task automatic random_phase(input int u);
    logic [31:0] d, a;
    logic        e;
    logic [2:0]  f3;
    bit          we;
    int          r;
    for (int w = 0; w < 16; w++) txn(u, 32'(4 * w), 1, 3'd2, $urandom, 0, d, e);
    for (int t = 0; t < 60; t++) begin
      r  = $urandom_range(0, 9);
      a  = 32'($urandom_range(0, 63));
      if (r == 0) a |= 32'h1 << $urandom_range(12, 31);
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      if (we && f3 > 3'd2) f3 = 3'($urandom_range(0, 2));
      if (r == 1) f3 = 3'($urandom_range(0, 7));
      txn(u, a, we, f3, $urandom, $urandom_range(0, 2), d, e);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u]      = 1'b0;
      req_valid[u]  = 1'b0;
      req_addr[u]   = '0;
      req_we[u]     = 1'b0;
      req_funct3[u] = '0;
      req_wdata[u]  = '0;
      rsp_ready[u]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_req_ready", 32'(req_ready[u]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[u], 32'd0);
      check("reset_rsp_err", 32'(rsp_err[u]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      directed(u);
      random_phase(u);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
